// File: rtl/mask_share_encoder.sv
// Boolean-masks one plain word into d shares in bit-interleaved layout (bit j of share k at j*d+k).
// Optional `MASK_SHARE_ENCODER_ZEROIZE_EN clears the plain and share registers once they are no longer needed.
module mask_share_encoder #(
    parameter int d    = 2,
    parameter int word = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [word-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [(d-1)*word-1:0]   rnd_in,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    output logic [d*word-1:0]       out_shares,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RND  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state;
    logic [word-1:0] p;

    // Share k>=1 is mask k; share 0 carries the plain value XOR all masks.
    function automatic logic [d*word-1:0] encode(
        input logic [word-1:0]       plain,
        input logic [(d-1)*word-1:0] masks
    );
        logic [word-1:0]   acc;
        logic [word-1:0]   m;
        logic [d*word-1:0] v;
        v   = '0;
        acc = plain;
        for (int k = 1; k < d; k++) begin
            m   = masks[(k-1)*word +: word];
            acc = acc ^ m;
            for (int j = 0; j < word; j++) begin
                v[j*d+k] = m[j];
            end
        end
        for (int j = 0; j < word; j++) begin
            v[j*d] = acc[j];
        end
        return v;
    endfunction

    // Handshake outputs are registered alongside the state so each one is a pure state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            rnd_ready  <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            p          <= '0;
            out_shares <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p         <= in_data;
                        state     <= RND;
                        in_ready  <= 1'b0;
                        rnd_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RND: begin
                    if (rnd_valid) begin
                        out_shares <= encode(p, rnd_in);
`ifdef MASK_SHARE_ENCODER_ZEROIZE_EN
                        p          <= '0;
`endif
                        state      <= OUT;
                        rnd_ready  <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
`ifdef MASK_SHARE_ENCODER_ZEROIZE_EN
                        out_shares <= '0;
`endif
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    rnd_ready <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_share_encoder.sv
// Self-checking bench for mask_share_encoder: directed scenarios plus randomized words, d=2 and d=3 instances.
module tb_mask_share_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // d=2, word=13 instance
    logic [12:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [12:0] rnd_in    = '0;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic [25:0] out_shares;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    mask_share_encoder #(.d(2), .word(13)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out_shares(out_shares), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    // d=3, word=13 instance
    logic [12:0] in_data3   = '0;
    logic        in_valid3  = 1'b0;
    logic        in_ready3;
    logic [25:0] rnd_in3    = '0;
    logic        rnd_valid3 = 1'b0;
    logic        rnd_ready3;
    logic [38:0] out_shares3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic        busy3;

    mask_share_encoder #(.d(3), .word(13)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .rnd_in(rnd_in3), .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3),
        .out_shares(out_shares3), .out_valid(out_valid3), .out_ready(out_ready3),
        .busy(busy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pull share k out of an interleaved vector with dd shares.
    function automatic logic [12:0] get_share(input logic [63:0] v, input int dd, input int k);
        logic [12:0] r;
        r = '0;
        for (int j = 0; j < 13; j++) r[j] = v[j*dd+k];
        return r;
    endfunction

    // Reference layout for d=2: share0 = data ^ mask, share1 = mask.
    function automatic logic [25:0] model2(input logic [12:0] data, input logic [12:0] mask);
        logic [25:0] v;
        logic [12:0] s0;
        s0 = data ^ mask;
        for (int j = 0; j < 13; j++) begin
            v[2*j]   = s0[j];
            v[2*j+1] = mask[j];
        end
        return v;
    endfunction

    task automatic encode2(input logic [12:0] data, input logic [12:0] mask,
                           input int rdly, input int odly, input bit junk,
                           input bit pend, input logic [12:0] next);
        logic [25:0] expv;
        expv = model2(data, mask);
        if (junk) begin
            in_valid  = 1'b0;
            rnd_in    = ~mask;
            rnd_valid = 1'b1;
            step();
            rnd_valid = 1'b0;
            chk("junk_rnd_busy", {63'd0, busy}, 64'd0);
            chk("junk_rnd_ready", {63'd0, rnd_ready}, 64'd0);
        end
        in_data  = data;
        in_valid = 1'b1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_data  = 13'($urandom);
        chk("rnd_ready_t1", {63'd0, rnd_ready}, 64'd1);
        chk("busy_rnd", {63'd0, busy}, 64'd1);
        chk("in_ready_rnd", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < rdly; i++) begin
            step();
            chk("stall_busy", {63'd0, busy}, 64'd1);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd0);
        end
        rnd_in    = mask;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        rnd_in    = 13'($urandom);
        chk("out_valid_t2", {63'd0, out_valid}, 64'd1);
        chk("share0", {51'd0, get_share({38'd0, out_shares}, 2, 0)}, {51'd0, data ^ mask});
        chk("share1", {51'd0, get_share({38'd0, out_shares}, 2, 1)}, {51'd0, mask});
        chk("xor_shares", {51'd0, get_share({38'd0, out_shares}, 2, 0) ^ get_share({38'd0, out_shares}, 2, 1)},
            {51'd0, data});
        if (pend) begin
            in_data  = next;
            in_valid = 1'b1;
        end
        for (int i = 0; i < odly; i++) begin
            step();
            chk("bp_shares", {38'd0, out_shares}, {38'd0, expv});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("done_in_ready", {63'd0, in_ready}, 64'd1);
        chk("done_out_valid", {63'd0, out_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
`ifdef MASK_SHARE_ENCODER_ZEROIZE_EN
        chk("zeroize_shares", {38'd0, out_shares}, 64'd0);
        chk("zeroize_p", {51'd0, dut.p}, 64'd0);
`else
        chk("persist_shares", {38'd0, out_shares}, {38'd0, expv});
        chk("persist_p", {51'd0, dut.p}, {51'd0, data});
`endif
    endtask

    initial begin
        logic [12:0] rd;
        logic [12:0] rm;
        logic [12:0] s0;
        logic [12:0] s1;
        logic [12:0] s2;

        repeat (3) step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_rnd_ready", {63'd0, rnd_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_shares", {38'd0, out_shares}, 64'd0);
        chk("rst_p", {51'd0, dut.p}, 64'd0);
        rst = 1'b0;
        step();

        // Directed d=2 vector, best-case latency.
        encode2(13'h1ABC, 13'h0F0F, 0, 0, 1'b0, 1'b0, 13'h0);
        chk("vec_model_share0", {51'd0, 13'h1ABC ^ 13'h0F0F}, {51'd0, 13'h15B3});

        // Randomness stall of 5 cycles with an early rnd_valid pulse.
        encode2(13'h0123, 13'h1A5A, 5, 0, 1'b1, 1'b0, 13'h0);

        // Backpressure of 4 cycles with the next word pending.
        encode2(13'h1F00, 13'h00FF, 0, 4, 1'b0, 1'b1, 13'h0777);
        encode2(13'h0777, 13'h1234, 1, 0, 1'b0, 1'b0, 13'h0);

        // Reset while a word sits in RND.
        in_data  = 13'h0BAD;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_shares", {38'd0, out_shares}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        encode2(13'h1357, 13'h0ACE, 0, 1, 1'b0, 1'b0, 13'h0);

        // Randomized words.
        for (int n = 0; n < 20; n++) begin
            rd = 13'($urandom);
            rm = 13'($urandom);
            encode2(rd, rm, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 13'h0);
        end

        // d=3 directed vector.
        chk("d3_rst_in_ready", {63'd0, in_ready3}, 64'd1);
        in_data3  = 13'h1FFF;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        chk("d3_rnd_ready", {63'd0, rnd_ready3}, 64'd1);
        rnd_in3    = {13'h0AAA, 13'h1555};
        rnd_valid3 = 1'b1;
        step();
        rnd_valid3 = 1'b0;
        chk("d3_out_valid", {63'd0, out_valid3}, 64'd1);
        s0 = get_share({25'd0, out_shares3}, 3, 0);
        s1 = get_share({25'd0, out_shares3}, 3, 1);
        s2 = get_share({25'd0, out_shares3}, 3, 2);
        chk("d3_share0", {51'd0, s0}, 64'h0000);
        chk("d3_share1", {51'd0, s1}, 64'h1555);
        chk("d3_share2", {51'd0, s2}, 64'h0AAA);
        chk("d3_xor", {51'd0, s0 ^ s1 ^ s2}, 64'h1FFF);
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
        chk("d3_done_in_ready", {63'd0, in_ready3}, 64'd1);
        chk("d3_done_busy", {63'd0, busy3}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mask_share_encoder.md
# mask_share_encoder

Converts one unmasked `word`-bit value into a `d`-share Boolean-masked value, in the share-interleaved layout the masked SHA gadgets consume. It sits at the input boundary of the masked datapath and feeds gadgets such as the SHA majority gadget. It draws fresh randomness from the PRNG through its own handshake, so no plain value ever leaves the block. All share values are produced from registers; there is no combinational path from plain input to output.

## Interface
Parameters:
- `d`, default 2: number of shares; must be 2 or more.
- `word`, default 13: width of the unmasked value in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  word  plain value to be masked.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data`.
- `rnd_in`  in  (d-1)*word  fresh mask bits; mask `k` (k=1..d-1) is `rnd_in[(k-1)*word +: word]`.
- `rnd_valid`  in  1  `rnd_in` is valid.
- `rnd_ready`  out  1  block consumes `rnd_in`.
- `out_shares`  out  d*word  masked value; bit `j` of share `k` is at index `j*d+k`.
- `out_valid`  out  1  `out_shares` is valid.
- `out_ready`  in  1  downstream consumes `out_shares`.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, RND and OUT. All handshake outputs are decoded from the state only:
  - IDLE: `in_ready`=1.
  - RND: `rnd_ready`=1.
  - OUT: `out_valid`=1.
- IDLE → RND when `in_valid && in_ready`. The block captures `in_data` into the plain register `p`.
- RND → OUT when `rnd_valid`. The share registers load:
  - share `k` = mask `k`, for k ≥ 1;
  - share 0 = `p` XOR every mask.
- The block waits in RND for any number of cycles while `rnd_valid`=0.
- OUT → IDLE when `out_ready`. `out_shares` holds a stable value for the whole time the block is in OUT.
- No overlap between words: `in_ready`=0 in RND and OUT.
- Each accepted mask is used exactly once. Masks are never reused across words.
- `rnd_valid` outside RND is ignored, and no randomness is consumed.
- `in_valid` outside IDLE is ignored. The upstream source holds its data until `in_ready`.
- Asserting `rst` in any state returns the FSM to IDLE. An in-flight word is discarded and no partial output is signalled.
- `busy`=1 in RND and OUT.

## Timing
- Reset values:
  - `in_ready`=1;
  - `rnd_ready`=0, `out_valid`=0, `busy`=0;
  - `out_shares`=0, `p`=0.
- Best-case latency, with the input handshake in cycle t:
  - `rnd_ready`=1 in cycle t+1;
  - if `rnd_valid`=1 in t+1, `out_valid`=1 in t+2;
  - if `out_ready`=1 in t+2, `in_ready`=1 in t+3.
- Maximum throughput: one word per 3 cycles.
- `out_shares` changes only on the RND → OUT edge, or on zeroization (see Configuration).

## Configuration
- `MASK_SHARE_ENCODER_ZEROIZE_EN` defined:
  - `p` clears to 0 on the same edge that loads the shares (RND → OUT);
  - the share registers clear to 0 on the OUT → IDLE edge.
  - As a result, the plain value exists only during RND, and `out_shares` reads 0 whenever `out_valid`=0.
- Macro undefined: `p` and the share registers keep their last values until they are next loaded.

## Test plan
- Reset: hold `rst` high mid-RND with a word captured → after release, `in_ready`=1, `out_valid`=0, `out_shares`=0, and the next word encodes correctly.
- d=2, word=13:
  - stimulus: `in_data`=0x1ABC, then `rnd_in`=0x0F0F;
  - required: share1=0x0F0F and share0=0x15B3, interleaved into even/odd bits of `out_shares`;
  - required: `out_valid` rises 2 cycles after the input handshake.
- d=3:
  - stimulus: `in_data`=0x1FFF, `rnd_in`={0x0AAA,0x1555};
  - required: share1=0x1555, share2=0x0AAA, share0=0x0000, and the XOR of all shares is 0x1FFF.
- Randomness stall: `rnd_valid` held low for 5 cycles → block stays in RND with `busy`=1 and `out_valid`=0. A later `rnd_valid` pulse produces output on the next cycle. `rnd_valid` pulses before the input handshake are not consumed.
- Backpressure: `out_ready` held low for 4 cycles → `out_shares` is constant, `in_ready`=0, and a pending `in_valid` is not accepted until one cycle after `out_ready`.
- Zeroize, with the macro defined: after the OUT → IDLE handshake, `out_shares`=0 and the internal `p`=0. With the macro undefined, the last shares persist.
